// File: rtl/tm1638_pkg.sv
// tm1638_pkg: digit-code constants, overflow threshold helper and converter FSM states
package tm1638_pkg;
  localparam logic [4:0] DIG_BLANK = 5'h10;
  localparam logic [4:0] DIG_MAX = 5'd9;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_BLANK, S_DONE} state_t;
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/bcd_add3_nibble.sv
// bcd_add3_nibble: double-dabble correction, adds 3 to a BCD nibble that is 5 or more
module bcd_add3_nibble (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

// File: rtl/bcd_digit_source.sv
// bcd_digit_source: serial binary-to-BCD converter with leading-zero blanking feeding the TM1638 driver
module bcd_digit_source
  import tm1638_pkg::*;
#(
  parameter int         WIDTH      = 27,
  parameter int         NDIG       = 8,
  parameter int         LZB        = 1,
  parameter logic [4:0] BLANK_CODE = DIG_BLANK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin_in,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [5*NDIG-1:0] digits
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam longint unsigned MAXV = pow10(NDIG) - 1;
  state_t              r_state;
  logic [WIDTH-1:0]    r_shift;
  logic [4*NDIG-1:0]   r_bcd;
  logic [CW-1:0]       r_cnt;
  logic                r_pend;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [5*NDIG-1:0]   r_digits;
  logic [4*NDIG-1:0]   w_adj;
  logic [5*NDIG-1:0]   w_codes;
  logic                w_lead;
  genvar i;
  generate
    for (i = 0; i < NDIG; i++) begin : g_add3
      bcd_add3_nibble u_add3 (.i_nib(r_bcd[4*i +: 4]), .o_nib(w_adj[4*i +: 4]));
    end
  endgenerate
  // w_lead stays set while every digit seen so far (from the top) is zero
  always_comb begin
    w_codes = '0;
    w_lead = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      w_lead = w_lead && (r_bcd[4*k +: 4] == 4'd0) && (k != 0);
      w_codes[5*k +: 5] = r_pend ? DIG_MAX :
                          (LZB != 0 && w_lead) ? BLANK_CODE : {1'b0, r_bcd[4*k +: 4]};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_digits <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_shift <= bin_in;
          r_bcd   <= '0;
          r_pend  <= 64'(bin_in) > MAXV;
          r_cnt   <= CW'(WIDTH);
          r_busy  <= 1'b1;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_bcd, r_shift} <= {w_adj[4*NDIG-2:0], r_shift, 1'b0};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_BLANK;
        end
        S_BLANK: begin
          r_digits <= w_codes;
          r_ovf    <= r_pend;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
  assign busy   = r_busy;
  assign done   = r_done;
  assign ovf    = r_ovf;
  assign digits = r_digits;
endmodule

// File: tb/tb_bcd_digit_source.sv
// tb_bcd_digit_source: randomized conversions checked against a decimal-arithmetic reference model
module tb_bcd_digit_source;
  localparam int W = 27;
  localparam int N = 8;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  bin_in = '0;
  logic          busy, done, ovf;
  logic [5*N-1:0] digits;
  int checks = 0;
  int errors = 0;

  bcd_digit_source #(.WIDTH(W), .NDIG(N), .LZB(1), .BLANK_CODE(5'h10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .ovf(ovf), .digits(digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Saturates to all nines above 99999999; otherwise digits beyond the decimal length are blank
  function automatic logic [5*N-1:0] ref_digits(input longint unsigned v);
    logic [5*N-1:0] r;
    longint unsigned t;
    int len;
    r = '0;
    if (v > 64'd99999999) begin
      for (int k = 0; k < N; k++) r[5*k +: 5] = 5'd9;
      return r;
    end
    len = 0;
    t = v;
    do begin len++; t = t / 10; end while (t != 0);
    t = v;
    for (int k = 0; k < N; k++) begin
      r[5*k +: 5] = (k >= len) ? 5'h10 : 5'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic convert(input logic [W-1:0] v, input bit poke);
    logic [5*N-1:0] prev_d;
    logic prev_o;
    int lat;
    bit seen;
    int extra;
    prev_d = digits;
    prev_o = ovf;
    @(negedge clk);
    start = 1'b1;
    bin_in = v;
    @(negedge clk);
    start = 1'b0;
    bin_in = W'($urandom);
    check("busy_rise", busy, 1'b1);
    seen = 0;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 5) begin
        check("hold_digits", digits, prev_d);
        check("hold_ovf", ovf, prev_o);
        if (poke) begin start = 1'b1; bin_in = W'($urandom); end
      end
      if (c == 6) start = 1'b0;
      if (done) begin seen = 1; lat = c; break; end
    end
    if (!seen) check("done_timeout", 0, 1);
    else begin
      check("latency", lat, W + 1);
      check("busy_fall", busy, 1'b0);
      check("digits", digits, ref_digits(64'(v)));
      check("ovf", ovf, 64'(v) > 64'd99999999);
      if (poke) begin start = 1'b1; bin_in = W'($urandom); end
      @(negedge clk);
      start = 1'b0;
      check("done_pulse", done, 1'b0);
      if (poke) begin
        extra = 0;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (done || busy) extra++;
        end
        check("ignored_starts", extra, 0);
        check("digits_kept", digits, ref_digits(64'(v)));
      end
    end
  endtask

  initial begin
    int extra;
    logic [W-1:0] v;
    repeat (3) @(negedge clk);
    check("rst_digits", digits, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_digits", digits, '0);
    check("idle_busy", busy, 1'b0);
    convert(27'd12345678, 0);
    convert(27'd507, 0);
    convert(27'd0, 0);
    convert(27'd100000000, 0);
    convert(27'd42, 0);
    convert(27'd99999999, 0);
    convert(27'h7FFFFFF, 0);
    convert(27'd8, 1);
    // abort a conversion partway through
    @(negedge clk);
    start = 1'b1;
    bin_in = 27'd99999999;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_digits", digits, '0);
    check("abort_busy", busy, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("abort_no_done", extra, 0);
    convert(27'd31415926, 0);
    for (int n = 0; n < 20; n++) begin
      v = (n % 3 == 2) ? W'($urandom) : W'($urandom_range(0, 99999999));
      if (n % 4 == 1) v = W'($urandom_range(0, 999));
      convert(v, n % 5 == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
